sync_fifo_flagged: RTL and testbench
====================================

# sync_fifo_flagged

Parametrised single-clock FIFO that generalises the team's basic synchronous FIFO. It adds an occupancy count and programmable almost-full/almost-empty levels. Sticky overflow/underflow error flags and a selectable first-word-fall-through (FWFT) read mode are also new. It sits between a producer and consumer in the same clock domain and is the default buffer for all new datapath blocks.

## Interface
- DATA_WIDTH, 8, word width in bits (≥1)
- DEPTH, 8, number of entries; power of two, ≥2
- AF_LEVEL, DEPTH-1, almost_full asserts when count ≥ AF_LEVEL (1..DEPTH)
- AE_LEVEL, 1, almost_empty asserts when count ≤ AE_LEVEL (0..DEPTH-1)
- FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- w_en  in  1  write request
- data_in  in  DATA_WIDTH  write data
- r_en  in  1  read request (FWFT: pop)
- data_out  out  DATA_WIDTH  read data
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_LEVEL
- almost_empty  out  1  count ≤ AE_LEVEL
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty
- clr_err  in  1  clears overflow/underflow

## Operation
- Pointers w_ptr, r_ptr are $clog2(DEPTH)+1 bits with an extra wrap bit. The low bits address memory and the MSB distinguishes full from empty. Both pointers wrap naturally modulo 2·DEPTH.
- Write accepted iff w_en && !full. Memory is written at w_ptr and w_ptr increments.
- Read accepted iff r_en && !empty. r_ptr increments.
- full/empty are sampled before the edge, so a write while full is rejected even with a simultaneous read. A read while empty is rejected even with a simultaneous write.
- count: +1 on write-only, −1 on read-only, unchanged on both or neither. count always equals w_ptr − r_ptr.
- full, empty, almost_full and almost_empty are decoded from the registered count, with no extra flop stage.
- overflow sets on w_en && full; underflow sets on r_en && empty. Both hold until clr_err. If set and clear happen in the same cycle, set wins.
- FWFT=0: data_out is registered. It loads mem[r_ptr] on an accepted read and holds its value otherwise.
- FWFT=1: data_out = mem[r_ptr] combinationally while !empty, and 0 while empty. r_en acknowledges and removes the head word.
- Rejected operations change no pointer, memory or data_out.

## Timing
- Reset (rst_n=0 at an edge): pointers and count = 0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=underflow=0, data_out=0. Memory contents are not reset.
- Reset mid-operation discards all stored words. Requests in the reset cycle are ignored.
- Write at edge N: count, empty and full update after edge N.
- FWFT=0 read latency is 1: data appears after the same edge that accepts the read.
- FWFT=1: the word written at edge N is valid on data_out after edge N, i.e. zero read latency.
- Full throughput: one write and one read per cycle at any fill level except the rejected boundary cases above.

## Structure
- Package fifo_pkg holds the ptr_width(depth) and cnt_width(depth) helper functions. All new FIFO variants share it.
- Sub-module fifo_mem (DATA_WIDTH, DEPTH) provides the storage array with a synchronous write port and an asynchronous read port. Pointers, count, flags and output register stay in the top module.
- Parameter checks (DEPTH power of two, levels in range) go in an elaboration-time assertion.

## Test plan
- DEPTH=8, FWFT=0: reset, write 0x01..0x08 → full=1 and count=8 after the 8th edge, almost_full=1 from count=7. Read 8 → data_out 0x01..0x08 in order, each one cycle after its read; empty=1 at end.
- Write while full (w_en=1, data 0xAA) → count stays 8, overflow=1 and sticky. Pulse clr_err → overflow=0.
- Read while empty → underflow=1, data_out holds its last value. clr_err and r_en in the same cycle while empty → underflow stays 1.
- Simultaneous read+write at count=4 for 20 cycles → count stays 4, pointers wrap past 2·DEPTH, and output order is preserved.
- FWFT=1: write 0x5A → data_out=0x5A immediately after the edge with no r_en. Pulse r_en → empty=1 and data_out=0.
- Fill to 5, assert rst_n=0 for one cycle → all outputs at reset values. The next write of 0x33 is read back as 0x33.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared helpers for FIFO variants: pointer and occupancy widths for a given depth.
package fifo_pkg;

  // Address bits plus one wrap bit that separates full from empty.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Occupancy must represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: synchronous write port, asynchronous read port, contents not reset.
module fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_WIDTH-1:0]    rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_flagged.sv
// Single-clock FIFO with occupancy count, almost-full/empty levels,
// sticky overflow/underflow flags and optional first-word-fall-through read.
module sync_fifo_flagged
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int AF_LEVEL   = DEPTH - 1,
  parameter int AE_LEVEL   = 1,
  parameter bit FWFT       = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        w_en,
  input  logic [DATA_WIDTH-1:0]       data_in,
  input  logic                        r_en,
  output logic [DATA_WIDTH-1:0]       data_out,
  output logic                        full,
  output logic                        empty,
  output logic                        almost_full,
  output logic                        almost_empty,
  output logic [cnt_width(DEPTH)-1:0] count,
  output logic                        overflow,
  output logic                        underflow,
  input  logic                        clr_err
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = cnt_width(DEPTH);
  localparam int AW = PW - 1;

  if ((DATA_WIDTH < 1) || (DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) ||
      (AF_LEVEL < 1) || (AF_LEVEL > DEPTH) ||
      (AE_LEVEL < 0) || (AE_LEVEL > DEPTH - 1)) begin : g_bad_params
    $error("sync_fifo_flagged: illegal parameter set");
  end

  logic [PW-1:0]         w_ptr, r_ptr;
  logic [CW-1:0]         count_q;
  logic                  ovf_q, unf_q;
  logic                  wr_ok, rd_ok;
  logic [DATA_WIDTH-1:0] head;

  // Flags come straight from the registered count so they move on the same edge.
  assign full         = (count_q == CW'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CW'(AF_LEVEL));
  assign almost_empty = (count_q <= CW'(AE_LEVEL));
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  assign wr_ok = w_en && !full;
  assign rd_ok = r_en && !empty;

  fifo_mem #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (w_ptr[AW-1:0]),
    .wdata (data_in),
    .raddr (r_ptr[AW-1:0]),
    .rdata (head)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_ptr   <= '0;
      r_ptr   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      if (wr_ok) w_ptr <= w_ptr + PW'(1);
      if (rd_ok) r_ptr <= r_ptr + PW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      // Set has priority over a same-cycle clear.
      ovf_q <= (w_en && full)  || (ovf_q && !clr_err);
      unf_q <= (r_en && empty) || (unf_q && !clr_err);
    end
  end

  // The wrap-bit pointer difference must always agree with the occupancy register.
  always_ff @(posedge clk) begin
    if (rst_n) assert (count_q == CW'(w_ptr - r_ptr));
  end

  if (FWFT) begin : g_fwft
    assign data_out = empty ? '0 : head;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] dout_q;
    always_ff @(posedge clk) begin
      if (!rst_n)     dout_q <= '0;
      else if (rd_ok) dout_q <= head;
    end
    assign data_out = dout_q;
  end

endmodule

// File: tb/tb_sync_fifo_flagged.sv
// Directed bench: a vector table for the standard-read FIFO plus hand sequences
// for wrap-around throughput, mid-operation reset and the FWFT variant.
module tb_sync_fifo_flagged;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Standard-read instance
  logic       s_rst_n, s_w_en, s_r_en, s_clr;
  logic [7:0] s_din, s_dout;
  logic [3:0] s_cnt;
  logic       s_full, s_empty, s_af, s_ae, s_ovf, s_unf;

  // FWFT instance
  logic       f_rst_n, f_w_en, f_r_en, f_clr;
  logic [7:0] f_din, f_dout;
  logic [3:0] f_cnt;
  logic       f_full, f_empty, f_af, f_ae, f_ovf, f_unf;

  sync_fifo_flagged #(.DATA_WIDTH(8), .DEPTH(8), .AF_LEVEL(7), .AE_LEVEL(1), .FWFT(1'b0)) u_std (
    .clk(clk), .rst_n(s_rst_n), .w_en(s_w_en), .data_in(s_din), .r_en(s_r_en),
    .data_out(s_dout), .full(s_full), .empty(s_empty), .almost_full(s_af),
    .almost_empty(s_ae), .count(s_cnt), .overflow(s_ovf), .underflow(s_unf),
    .clr_err(s_clr)
  );

  sync_fifo_flagged #(.DATA_WIDTH(8), .DEPTH(8), .AF_LEVEL(7), .AE_LEVEL(1), .FWFT(1'b1)) u_fw (
    .clk(clk), .rst_n(f_rst_n), .w_en(f_w_en), .data_in(f_din), .r_en(f_r_en),
    .data_out(f_dout), .full(f_full), .empty(f_empty), .almost_full(f_af),
    .almost_empty(f_ae), .count(f_cnt), .overflow(f_ovf), .underflow(f_unf),
    .clr_err(f_clr)
  );

  typedef struct {
    logic       rst_n, w_en, r_en, clr;
    logic [7:0] din;
    logic [7:0] dout;
    logic [3:0] cnt;
    logic       full, empty, af, ae, ovf, unf;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rst_n, w, r, c, input logic [7:0] din, dout,
                     input logic [3:0] cnt, input logic full, empty, af, ae, ovf, unf);
    vec_t v;
    v.rst_n = rst_n; v.w_en = w; v.r_en = r; v.clr = c; v.din = din;
    v.dout = dout; v.cnt = cnt; v.full = full; v.empty = empty;
    v.af = af; v.ae = ae; v.ovf = ovf; v.unf = unf;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic s_drive(input logic rst_n, w, r, c, input logic [7:0] din);
    s_rst_n = rst_n; s_w_en = w; s_r_en = r; s_clr = c; s_din = din;
  endtask

  task automatic f_drive(input logic rst_n, w, r, c, input logic [7:0] din);
    f_rst_n = rst_n; f_w_en = w; f_r_en = r; f_clr = c; f_din = din;
  endtask

  initial begin
    s_drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    f_drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

    // ---- vector table for the standard-read FIFO ----
    add(0, 0, 0, 0, 8'h00, 8'h00, 4'd0, 0, 1, 0, 1, 0, 0);        // reset
    for (int i = 1; i <= 8; i++)                                  // fill 0x01..0x08
      add(1, 1, 0, 0, 8'(i), 8'h00, 4'(i), i == 8, 0, i >= 7, i <= 1, 0, 0);
    add(1, 1, 0, 0, 8'hAA, 8'h00, 4'd8, 1, 0, 1, 0, 1, 0);        // write while full
    add(1, 0, 0, 0, 8'h00, 8'h00, 4'd8, 1, 0, 1, 0, 1, 0);        // overflow sticky
    add(1, 0, 0, 1, 8'h00, 8'h00, 4'd8, 1, 0, 1, 0, 0, 0);        // clr_err
    for (int i = 1; i <= 8; i++)                                  // drain in order
      add(1, 0, 1, 0, 8'h00, 8'(i), 4'(8 - i), 0, i == 8, (8 - i) >= 7, (8 - i) <= 1, 0, 0);
    add(1, 0, 1, 0, 8'h00, 8'h08, 4'd0, 0, 1, 0, 1, 0, 1);        // read while empty
    add(1, 0, 1, 1, 8'h00, 8'h08, 4'd0, 0, 1, 0, 1, 0, 1);        // set beats clear
    add(1, 0, 0, 1, 8'h00, 8'h08, 4'd0, 0, 1, 0, 1, 0, 0);        // clear alone

    foreach (vq[k]) begin
      s_drive(vq[k].rst_n, vq[k].w_en, vq[k].r_en, vq[k].clr, vq[k].din);
      if (k == 0) f_drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      else        f_drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      tick();
      chk("tbl_dout",  k, 32'(s_dout),  32'(vq[k].dout));
      chk("tbl_count", k, 32'(s_cnt),   32'(vq[k].cnt));
      chk("tbl_full",  k, 32'(s_full),  32'(vq[k].full));
      chk("tbl_empty", k, 32'(s_empty), 32'(vq[k].empty));
      chk("tbl_af",    k, 32'(s_af),    32'(vq[k].af));
      chk("tbl_ae",    k, 32'(s_ae),    32'(vq[k].ae));
      chk("tbl_ovf",   k, 32'(s_ovf),   32'(vq[k].ovf));
      chk("tbl_unf",   k, 32'(s_unf),   32'(vq[k].unf));
    end

    // ---- fill to 4, then 20 cycles of simultaneous read+write (pointers wrap) ----
    for (int i = 0; i < 4; i++) begin
      s_drive(1'b1, 1'b1, 1'b0, 1'b0, 8'(8'h10 + i));
      tick();
      chk("prefill_count", i, 32'(s_cnt), 32'(i + 1));
    end
    for (int i = 0; i < 20; i++) begin
      s_drive(1'b1, 1'b1, 1'b1, 1'b0, 8'(8'h14 + i));
      tick();
      chk("rw_dout",  i, 32'(s_dout), 32'(8'h10 + i));
      chk("rw_count", i, 32'(s_cnt),  32'd4);
    end

    // ---- count 5, reset mid-operation with a write request pending ----
    s_drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h77);
    tick();
    chk("pre_rst_count", 0, 32'(s_cnt), 32'd5);
    s_drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h99);
    tick();
    chk("rst_count", 0, 32'(s_cnt),   32'd0);
    chk("rst_empty", 0, 32'(s_empty), 32'd1);
    chk("rst_ae",    0, 32'(s_ae),    32'd1);
    chk("rst_full",  0, 32'(s_full),  32'd0);
    chk("rst_af",    0, 32'(s_af),    32'd0);
    chk("rst_dout",  0, 32'(s_dout),  32'd0);
    s_drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h33);
    tick();
    chk("post_rst_count", 0, 32'(s_cnt), 32'd1);
    s_drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    tick();
    chk("post_rst_dout",  0, 32'(s_dout),  32'h33);
    chk("post_rst_empty", 0, 32'(s_empty), 32'd1);
    s_drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

    // ---- FWFT instance ----
    f_drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    chk("fw_rst_dout", 0, 32'(f_dout), 32'd0);
    f_drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h5A);
    tick();
    chk("fw_dout",  0, 32'(f_dout),  32'h5A);
    chk("fw_count", 0, 32'(f_cnt),   32'd1);
    chk("fw_empty", 0, 32'(f_empty), 32'd0);
    f_drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    chk("fw_hold", 0, 32'(f_dout), 32'h5A);
    f_drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    tick();
    chk("fw_pop_empty", 0, 32'(f_empty), 32'd1);
    chk("fw_pop_dout",  0, 32'(f_dout),  32'd0);
    f_drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h11);
    tick();
    f_drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h22);
    tick();
    chk("fw_head",  1, 32'(f_dout), 32'h11);
    chk("fw_count", 1, 32'(f_cnt),  32'd2);
    f_drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    tick();
    chk("fw_head", 2, 32'(f_dout), 32'h22);
    tick();
    chk("fw_drain_dout",  0, 32'(f_dout),  32'd0);
    chk("fw_drain_empty", 0, 32'(f_empty), 32'd1);
    tick();
    chk("fw_unf",      0, 32'(f_unf),  32'd1);
    chk("fw_unf_dout", 0, 32'(f_dout), 32'd0);
    f_drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
